// File: rtl/green_house_pkg.sv
// Shared encodings and default constants for the greenhouse door controller.
package green_house_pkg;

    typedef enum logic [2:0] {
        DOOR_HOMING  = 3'd0,
        DOOR_CLOSED  = 3'd1,
        DOOR_OPENING = 3'd2,
        DOOR_OPEN    = 3'd3,
        DOOR_CLOSING = 3'd4,
        DOOR_REVERSE = 3'd5,
        DOOR_FAULT   = 3'd6
    } door_state_t;

    localparam int HOLD_CYCLES_DEF    = 20;
    localparam int TRAVEL_TIMEOUT_DEF = 50;
    localparam int DEAD_CYCLES_DEF    = 2;
    localparam int OPEN_COUNT_W       = 16;

endpackage

// File: rtl/green_house_sync2.sv
// Parameterizable-width two-flop synchronizer with synchronous active-high reset.
module green_house_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage1;

    always_ff @(posedge clk) begin
        if (reset) begin
            stage1 <= '0;
            q      <= '0;
        end else begin
            stage1 <= d;
            q      <= stage1;
        end
    end

endmodule

// File: rtl/green_house_door_ctrl.sv
// Greenhouse door motor sequencer: homing, hold-open, safe reversal and latched fault.
// Define GREEN_HOUSE_DOOR_SYNC_EN to pass the four sensor inputs through two-flop synchronizers.
module green_house_door_ctrl
    import green_house_pkg::*;
#(
    parameter int HOLD_CYCLES    = HOLD_CYCLES_DEF,
    parameter int TRAVEL_TIMEOUT = TRAVEL_TIMEOUT_DEF,
    parameter int DEAD_CYCLES    = DEAD_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    doorPIRIn,
    input  logic                    doorPIROut,
    input  logic                    doorOpenMax,
    input  logic                    doorCloseMax,
    output logic                    doorOpen,
    output logic                    doorClose,
    output logic [2:0]              doorState,
    output logic                    doorFault,
    output logic [OPEN_COUNT_W-1:0] openCount
);

    localparam int HOLD_W   = $clog2(HOLD_CYCLES + 1);
    localparam int TRAVEL_W = $clog2(TRAVEL_TIMEOUT + 1);
    localparam int DEAD_W   = $clog2(DEAD_CYCLES + 1);

    logic pirInS, pirOutS, openMaxS, closeMaxS;
    logic pir;

`ifdef GREEN_HOUSE_DOOR_SYNC_EN
    green_house_sync2 #(.WIDTH(4)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     ({doorPIRIn, doorPIROut, doorOpenMax, doorCloseMax}),
        .q     ({pirInS, pirOutS, openMaxS, closeMaxS})
    );
`else
    assign pirInS    = doorPIRIn;
    assign pirOutS   = doorPIROut;
    assign openMaxS  = doorOpenMax;
    assign closeMaxS = doorCloseMax;
`endif

    assign pir = pirInS | pirOutS;

    door_state_t state, nextState;
    logic [HOLD_W-1:0]   holdCnt;
    logic [TRAVEL_W-1:0] travelCnt;
    logic [DEAD_W-1:0]   deadCnt;

    logic travelExpired, holdDone, deadDone, openReached;

    assign travelExpired = (travelCnt == TRAVEL_W'(TRAVEL_TIMEOUT - 1));
    assign holdDone      = (holdCnt == '0);
    assign deadDone      = (deadCnt == DEAD_W'(DEAD_CYCLES - 1));
    assign openReached   = (state == DOOR_OPENING) && (nextState == DOOR_OPEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DOOR_HOMING;
        end else begin
            state <= nextState;
        end
    end

    // Contradictory limit switches outrank every other transition.
    always_comb begin
        nextState = state;
        if (state != DOOR_FAULT && openMaxS && closeMaxS) begin
            nextState = DOOR_FAULT;
        end else begin
            case (state)
                DOOR_HOMING:  nextState = closeMaxS ? DOOR_CLOSED : DOOR_CLOSING;
                DOOR_CLOSED:  if (pir) nextState = DOOR_OPENING;
                DOOR_OPENING: begin
                    if (openMaxS)           nextState = DOOR_OPEN;
                    else if (travelExpired) nextState = DOOR_FAULT;
                end
                DOOR_OPEN:    if (!pir && holdDone) nextState = DOOR_CLOSING;
                DOOR_CLOSING: begin
                    if (pir)                nextState = DOOR_REVERSE;
                    else if (closeMaxS)     nextState = DOOR_CLOSED;
                    else if (travelExpired) nextState = DOOR_FAULT;
                end
                DOOR_REVERSE: if (deadDone) nextState = DOOR_OPENING;
                DOOR_FAULT:   nextState = DOOR_FAULT;
                default:      nextState = DOOR_FAULT;
            endcase
        end
    end

    always_comb begin
        doorOpen  = (state == DOOR_OPENING);
        doorClose = (state == DOOR_CLOSING);
        doorFault = (state == DOOR_FAULT);
        doorState = state;
    end

    // Travel counter restarts on each fresh entry to a moving state.
    always_ff @(posedge clk) begin
        if (reset) begin
            travelCnt <= '0;
        end else if ((nextState == DOOR_OPENING || nextState == DOOR_CLOSING) && nextState != state) begin
            travelCnt <= '0;
        end else if ((state == DOOR_OPENING || state == DOOR_CLOSING) &&
                     travelCnt != TRAVEL_W'(TRAVEL_TIMEOUT)) begin
            travelCnt <= travelCnt + TRAVEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            holdCnt <= '0;
        end else if (openReached || (state == DOOR_OPEN && pir)) begin
            holdCnt <= HOLD_W'(HOLD_CYCLES);
        end else if (state == DOOR_OPEN && !holdDone) begin
            holdCnt <= holdCnt - HOLD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || state != DOOR_REVERSE) begin
            deadCnt <= '0;
        end else if (deadCnt != DEAD_W'(DEAD_CYCLES)) begin
            deadCnt <= deadCnt + DEAD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            openCount <= '0;
        end else if (openReached && openCount != '1) begin
            openCount <= openCount + OPEN_COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_green_house_door_ctrl.sv
// Directed self-checking bench for green_house_door_ctrl (HOLD=4, TIMEOUT=10, DEAD=2).
module tb_green_house_door_ctrl;
    import green_house_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        doorPIRIn, doorPIROut, doorOpenMax, doorCloseMax;
    logic        doorOpen, doorClose, doorFault;
    logic [2:0]  doorState;
    logic [15:0] openCount;

    int compared   = 0;
    int mismatched = 0;

    green_house_door_ctrl #(
        .HOLD_CYCLES    (4),
        .TRAVEL_TIMEOUT (10),
        .DEAD_CYCLES    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .doorPIRIn    (doorPIRIn),
        .doorPIROut   (doorPIROut),
        .doorOpenMax  (doorOpenMax),
        .doorCloseMax (doorCloseMax),
        .doorOpen     (doorOpen),
        .doorClose    (doorClose),
        .doorState    (doorState),
        .doorFault    (doorFault),
        .openCount    (openCount)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic pin, input logic pout,
                                 input logic omax, input logic cmax);
        reset        = rst;
        doorPIRIn    = pin;
        doorPIROut   = pout;
        doorOpenMax  = omax;
        doorCloseMax = cmax;
    endtask

    task automatic checkOutput(input string tag, input door_state_t expState,
                               input logic expOpen, input logic expClose,
                               input logic expFault, input logic [15:0] expCount);
        compared++;
        assert (doorState === expState) else begin
            mismatched++;
            $error("[TB] FAIL %s state: got %0d expected %0d", tag, doorState, expState);
        end
        compared++;
        assert ({doorOpen, doorClose, doorFault} === {expOpen, expClose, expFault}) else begin
            mismatched++;
            $error("[TB] FAIL %s open/close/fault: got %b expected %b", tag,
                   {doorOpen, doorClose, doorFault}, {expOpen, expClose, expFault});
        end
        compared++;
        assert (openCount === expCount) else begin
            mismatched++;
            $error("[TB] FAIL %s openCount: got %0d expected %0d", tag, openCount, expCount);
        end
    endtask

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(3);
        checkOutput("reset", DOOR_HOMING, 0, 0, 0, 16'd0);

`ifdef GREEN_HOUSE_DOOR_SYNC_EN
        // Synchronized build: home against delayed limits, then check the 3-cycle fault latency.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        begin
            int waited = 0;
            while (doorState !== DOOR_CLOSED && waited < 10) begin
                tick();
                waited++;
            end
            compared++;
            assert (doorState === DOOR_CLOSED) else begin
                mismatched++;
                $error("[TB] FAIL sync_home: state %0d not CLOSED after %0d cycles", doorState, waited);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("sync_lim_1", DOOR_CLOSED, 0, 0, 0, 16'd0);
        tick();
        checkOutput("sync_lim_2", DOOR_CLOSED, 0, 0, 0, 16'd0);
        tick();
        checkOutput("sync_lim_3", DOOR_FAULT, 0, 0, 1, 16'd0);
`else
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("home_closed", DOOR_CLOSED, 0, 0, 0, 16'd0);

        // Full open/close cycle
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("open_start", DOOR_OPENING, 1, 0, 0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        checkOutput("opening_3", DOOR_OPENING, 1, 0, 0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("open_entry", DOOR_OPEN, 0, 0, 0, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("open_dwell", DOOR_OPEN, 0, 0, 0, 16'd1);
        end
        tick();
        checkOutput("close_start", DOOR_CLOSING, 0, 1, 0, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("closed_again", DOOR_CLOSED, 0, 0, 0, 16'd1);

        // Hold extension from outer PIR on the third OPEN cycle
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("open2_start", DOOR_OPENING, 1, 0, 0, 16'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("open2_entry", DOOR_OPEN, 0, 0, 0, 16'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("hold_ext", DOOR_OPEN, 0, 0, 0, 16'd2);
            tick();
        end
        checkOutput("hold_ext_close", DOOR_CLOSING, 0, 1, 0, 16'd2);

        // Reversal: PIR beats a simultaneous fully-closed limit
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("reverse_1", DOOR_REVERSE, 0, 0, 0, 16'd2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("reverse_2", DOOR_REVERSE, 0, 0, 0, 16'd2);
        tick();
        checkOutput("reverse_open", DOOR_OPENING, 1, 0, 0, 16'd2);

        // Opening timeout: 10 cycles after entering OPENING
        tick(9);
        checkOutput("timeout_pre", DOOR_OPENING, 1, 0, 0, 16'd2);
        tick();
        checkOutput("timeout_fault", DOOR_FAULT, 0, 0, 1, 16'd2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        tick(3);
        checkOutput("fault_latched", DOOR_FAULT, 0, 0, 1, 16'd2);

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("fault_reset", DOOR_HOMING, 0, 0, 0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("rehome", DOOR_CLOSED, 0, 0, 0, 16'd0);

        // Open limit alone is ignored in CLOSED; both limits force FAULT
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("omax_ignored", DOOR_CLOSED, 0, 0, 0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("both_limits", DOOR_FAULT, 0, 0, 1, 16'd0);

        // Homing without closed limit, then reset while closing
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("home_closing", DOOR_CLOSING, 0, 1, 0, 16'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("reset_midtravel", DOOR_HOMING, 0, 0, 0, 16'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("rehome_2", DOOR_CLOSED, 0, 0, 0, 16'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
